// File: rtl/pe_cmd_pkg.sv
// pe_cmd_pkg: shared PE command encodings and sequencer state type
package pe_cmd_pkg;
  typedef enum logic [3:0] {
    CMD_MAC         = 4'd0,
    CMD_SHIFT_UP    = 4'd1,
    CMD_SHIFT_DOWN  = 4'd2,
    CMD_SHIFT_LEFT  = 4'd3,
    CMD_SHIFT_RIGHT = 4'd4,
    CMD_OVR_A       = 4'd5,
    CMD_OVR_B       = 4'd6,
    CMD_OVR_S       = 4'd7,
    CMD_RESET       = 4'd8
  } pe_cmd_e;
  typedef enum logic [2:0] {IDLE, DROP, EXEC, RETIRE, ERR} seq_state_e;
endpackage

// File: rtl/pe_cmd_fifo.sv
// pe_cmd_fifo: show-ahead synchronous instruction FIFO
// ports: CLK/RST clock and sync reset; push/din write; pop advances head; full/empty status
module pe_cmd_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge CLK)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/pe_cmd_sequencer.sv
// pe_cmd_sequencer: queues host instructions and runs the lock-step ack/ready handshake across a PE row
// ports: CLK/RST clock and sync reset; enable gates new instructions; instr_* host push;
//        pe_ready per-PE ready; cmd/ack broadcast; busy/instr_done/issue_count/timeout_err status
module pe_cmd_sequencer
  import pe_cmd_pkg::*;
#(
  parameter int NUM_PE        = 4,
  parameter int command_width = 4,
  parameter int DEPTH         = 8,
  parameter int REPEAT_WIDTH  = 8,
  parameter int TIMEOUT       = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     enable,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [command_width-1:0] instr_cmd,
  input  logic [REPEAT_WIDTH-1:0]  instr_repeat,
  input  logic [NUM_PE-1:0]        pe_ready,
  output logic [command_width-1:0] cmd,
  output logic                     ack,
  output logic                     busy,
  output logic                     instr_done,
  output logic [15:0]              issue_count,
  output logic                     timeout_err
);
  localparam int TW = $clog2(TIMEOUT);
  seq_state_e state, state_nxt;
  logic [command_width-1:0] cur_cmd;
  logic [REPEAT_WIDTH-1:0] cur_rem;
  logic [TW-1:0] timer;
  logic [command_width+REPEAT_WIDTH-1:0] head;
  logic full, empty, pop, all_rdy, none_rdy, timer_exp;
  assign instr_ready = !full;
  assign all_rdy = &pe_ready;
  assign none_rdy = ~|pe_ready;
  assign timer_exp = timer == TW'(TIMEOUT - 1);
  assign pop = (state == RETIRE) && (cur_rem == '0);
  pe_cmd_fifo #(.WIDTH(command_width + REPEAT_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (instr_valid),
    .pop   (pop),
    .din   ({instr_cmd, instr_repeat}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge CLK)
    state <= RST ? IDLE : state_nxt;
  // Partial pe_ready satisfies neither wait: DROP needs all clear, EXEC needs all set.
  always_comb
    state_nxt = state == IDLE   ? ((enable && !empty) ? DROP : IDLE)
              : state == DROP   ? (none_rdy ? EXEC : timer_exp ? ERR : DROP)
              : state == EXEC   ? (all_rdy ? RETIRE : timer_exp ? ERR : EXEC)
              : state == RETIRE ? ((cur_rem == '0) ? IDLE : DROP)
              : ERR;
  always_comb begin
    ack = state != EXEC;
    busy = state inside {DROP, EXEC, RETIRE};
    instr_done = pop;
    timeout_err = state == ERR;
    cmd = cur_cmd;
  end
  // cur_cmd only loads on IDLE->DROP, so cmd cannot move while a PE is executing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_cmd <= '0;
      cur_rem <= '0;
      timer <= '0;
      issue_count <= '0;
    end else begin
      if (state == IDLE && state_nxt == DROP) {cur_cmd, cur_rem} <= head;
      if (state == RETIRE && cur_rem != '0) cur_rem <= cur_rem - 1'b1;
      if (state == RETIRE) issue_count <= issue_count + 16'd1;
      timer <= (state_nxt != state) ? '0 : timer + 1'b1;
    end
  end
endmodule
